// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    // Bytes per instruction word; the fetch and response PCs advance by this.
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // One prefetch-queue entry: fetched instruction plus the PC it came from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry FIFO of fetch entries with synchronous clear that
//               takes priority over push and pop. DEPTH is a power of two so
//               the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  fetch_entry_t                 din,
    input  logic                         pop,
    output fetch_entry_t                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Head of queue is always presented; the consumer qualifies it with count.
    assign dout = mem[rd_ptr];

    // Storage, pointers and occupancy; clear empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch_stage
// Description : Instruction-fetch stage with up to DEPTH requests in flight
//               and a DEPTH-entry prefetch queue toward ID. Redirects
//               (flush/branch) restart fetch and drop stale responses.
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        flush_i,
    input  logic        halt_i,
    input  logic        branch_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        ack_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W:0]   in_use;
    logic [31:0]      target;
    logic             redirect;
    logic             grant;
    logic             resp_ok;
    logic             resp_keep;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // Issue, response and pop qualifiers. Reset gates the request so the
    // memory never sees one while rstn_i is low.
    always_comb begin
        redirect         = flush_i | branch_i;
        target           = pc_i & ~32'd3;
        in_use           = {1'b0, occupancy} + {1'b0, outstanding};
        mem_req_o        = rstn_i & !halt_i & !redirect & (in_use < (CNT_W+1)'(DEPTH));
        mem_addr_o       = fetch_pc;
        grant            = mem_req_o & mem_gnt_i;
        // A response with nothing outstanding is a protocol error and ignored.
        resp_ok          = mem_rvalid_i & (outstanding != '0);
        resp_keep        = resp_ok & (discard == '0);
        push             = resp_keep & !redirect;
        pop              = valid_o & ack_i & !halt_i;
        outstanding_next = outstanding + CNT_W'(grant) - CNT_W'(resp_ok);
        push_entry.instr = mem_rdata_i;
        push_entry.pc    = resp_pc;
    end

    // PC registers and in-flight bookkeeping. On redirect every response
    // still in flight after this cycle becomes stale and is discarded.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect) begin
                fetch_pc <= target;
                resp_pc  <= target;
                discard  <= outstanding_next;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + INSTR_BYTES;
                end
                if (resp_keep) begin
                    resp_pc <= resp_pc + INSTR_BYTES;
                end
                if (resp_ok && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst_n (rstn_i),
        .clear (redirect),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .count (occupancy)
    );

    // Head of the prefetch queue toward ID.
    always_comb begin
        valid_o = (occupancy != '0);
        instr_o = head.instr;
        pc_o    = head.pc;
    end

    // Protocol and capacity invariants.
    a_no_spurious_rvalid : assert property (@(posedge clk) disable iff (!rstn_i)
        !(mem_rvalid_i && (outstanding == '0)));
    a_capacity : assert property (@(posedge clk) disable iff (!rstn_i)
        (in_use <= (CNT_W+1)'(DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_prefetch_stage
// Description : Directed self-checking bench for if_prefetch_stage with an
//               in-order memory model of configurable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_stage;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        flush_i;
    logic        halt_i;
    logic        branch_i;
    logic [31:0] pc_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        ack_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;
    int n_grant = 0;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    if_prefetch_stage #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rstn_i       (rstn_i),
        .flush_i      (flush_i),
        .halt_i       (halt_i),
        .branch_i     (branch_i),
        .pc_i         (pc_i),
        .valid_o      (valid_o),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .ack_i        (ack_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Memory contents: each word is its address XOR 0xA5A5_0000.
    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: note the handshake just before the edge, then drive the
    // memory response for the new cycle.
    task automatic step();
        logic        g;
        logic [31:0] a;
        #1;
        g = mem_req_o & mem_gnt_i;
        a = mem_addr_o;
        @(posedge clk);
        #1;
        cyc++;
        if (g) begin
            n_grant++;
            pend_addr.push_back(a);
            pend_due.push_back(cyc - 1 + lat);
        end
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = data_of(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
        end
        #1;
    endtask

    task automatic do_reset();
        rstn_i       = 1'b0;
        flush_i      = 1'b0;
        halt_i       = 1'b0;
        branch_i     = 1'b0;
        pc_i         = '0;
        ack_i        = 1'b0;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        pend_addr.delete();
        pend_due.delete();
        step();
        step();
        pend_addr.delete();
        pend_due.delete();
        mem_rvalid_i = 1'b0;
        rstn_i  = 1'b1;
        n_grant = 0;
        #1;
    endtask

    initial begin
        int waited;
        int base;

        // ---------------- reset state
        do_reset();
        rstn_i = 1'b0;
        #1;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_req",   {31'd0, mem_req_o}, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc",    pc_o, 32'd0);

        // ---------------- streaming: gnt=1, latency 1, ack=1
        lat = 1;
        do_reset();
        ack_i = 1'b1;
        check("s_addr0", mem_addr_o, 32'h0);
        check("s_req0",  {31'd0, mem_req_o}, 32'd1);
        step();
        check("s_addr1", mem_addr_o, 32'h4);
        check("s_valid1", {31'd0, valid_o}, 32'd0);
        step();
        check("s_addr2", mem_addr_o, 32'h8);
        check("s_valid2", {31'd0, valid_o}, 32'd1);
        check("s_pc2",   pc_o, 32'h0);
        check("s_in2",   instr_o, 32'hA5A5_0000);
        step();
        check("s_addr3", mem_addr_o, 32'hC);
        check("s_pc3",   pc_o, 32'h4);
        check("s_in3",   instr_o, 32'hA5A5_0004);

        // ---------------- queue fill: ack=0
        lat = 1;
        do_reset();
        for (int i = 0; i < 8; i++) step();
        check("f_grants", n_grant, 4);
        check("f_req",    {31'd0, mem_req_o}, 32'd0);
        check("f_pc0",    pc_o, 32'h0);
        ack_i = 1'b1;
        #1;
        check("f_req_ack", {31'd0, mem_req_o}, 32'd0);
        step();
        ack_i = 1'b0;
        #1;
        check("f_pc1",   pc_o, 32'h4);
        check("f_req10", {31'd0, mem_req_o}, 32'd1);
        check("f_addr10", mem_addr_o, 32'h10);
        step();
        check("f_req_after", {31'd0, mem_req_o}, 32'd0);
        check("f_grants5", n_grant, 5);
        ack_i = 1'b1;
        check("f_d0", pc_o, 32'h4);
        step();
        check("f_d1", pc_o, 32'h8);
        step();
        check("f_d2", pc_o, 32'hC);
        step();
        check("f_d3", pc_o, 32'h10);
        check("f_d3i", instr_o, 32'hA5A5_0010);

        // ---------------- branch with three in flight, latency 5
        lat = 5;
        do_reset();
        ack_i = 1'b1;
        step();
        step();
        step();
        branch_i = 1'b1;
        pc_i     = 32'h100;
        #1;
        check("b_req_redir", {31'd0, mem_req_o}, 32'd0);
        step();
        branch_i = 1'b0;
        #1;
        check("b_addr", mem_addr_o, 32'h100);
        waited = 0;
        while (!valid_o && waited < 20) begin
            step();
            waited++;
        end
        check("b_wait", waited, 6);
        check("b_pc",   pc_o, 32'h100);
        check("b_in",   instr_o, 32'hA5A5_0100);

        // ---------------- flush coinciding with a response, 2 outstanding
        lat = 2;
        do_reset();
        step();
        step();
        check("x_rv", {31'd0, mem_rvalid_i}, 32'd1);
        flush_i = 1'b1;
        pc_i    = 32'h40;
        step();
        flush_i = 1'b0;
        #1;
        check("x_valid3", {31'd0, valid_o}, 32'd0);
        check("x_addr3",  mem_addr_o, 32'h40);
        step();
        check("x_valid4", {31'd0, valid_o}, 32'd0);
        step();
        check("x_valid5", {31'd0, valid_o}, 32'd0);
        step();
        check("x_valid6", {31'd0, valid_o}, 32'd1);
        check("x_pc6",    pc_o, 32'h40);
        check("x_in6",    instr_o, 32'hA5A5_0040);

        // ---------------- halt with two responses pending, ack=1
        lat = 3;
        do_reset();
        ack_i = 1'b1;
        step();
        step();
        halt_i = 1'b1;
        base   = n_grant;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("h_req", {31'd0, mem_req_o}, 32'd0);
            if (i >= 3) check("h_instr", instr_o, 32'hA5A5_0000);
            step();
        end
        check("h_grants", n_grant, base);
        check("h_valid",  {31'd0, valid_o}, 32'd1);
        halt_i = 1'b0;
        check("h_pc0", pc_o, 32'h0);
        step();
        check("h_pc1", pc_o, 32'h4);
        check("h_in1", instr_o, 32'hA5A5_0004);

        // ---------------- branch to unaligned target during halt
        lat = 1;
        do_reset();
        halt_i   = 1'b1;
        branch_i = 1'b1;
        pc_i     = 32'h203;
        #1;
        check("hb_req0", {31'd0, mem_req_o}, 32'd0);
        step();
        branch_i = 1'b0;
        #1;
        check("hb_req1", {31'd0, mem_req_o}, 32'd0);
        step();
        halt_i = 1'b0;
        #1;
        check("hb_req2",  {31'd0, mem_req_o}, 32'd1);
        check("hb_addr2", mem_addr_o, 32'h200);

        // ---------------- address wrap at the top of memory
        lat = 1;
        do_reset();
        ack_i    = 1'b1;
        branch_i = 1'b1;
        pc_i     = 32'hFFFF_FFF8;
        step();
        branch_i = 1'b0;
        #1;
        check("w_a0", mem_addr_o, 32'hFFFF_FFF8);
        step();
        check("w_a1", mem_addr_o, 32'hFFFF_FFFC);
        step();
        check("w_a2", mem_addr_o, 32'h0000_0000);
        check("w_r2", {31'd0, mem_req_o}, 32'd1);
        check("w_pc2", pc_o, 32'hFFFF_FFF8);
        step();
        check("w_a3", mem_addr_o, 32'h0000_0004);
        check("w_pc3", pc_o, 32'hFFFF_FFFC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
